// File: rtl/mult_operand_sequencer_if.sv
// Operand/multiplier/result signal bundle for the multiplier operand sequencer.
// The master modport is the sequencer side. The slave modport is the surrounding environment.
interface mult_operand_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        mul_reset;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic [15:0] mul_prod;
  logic        mul_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        out_timeout;
  logic        busy;

  modport master (
    input  in_valid, in_a, in_b, mul_prod, mul_ready, out_ready,
    output in_ready, mul_reset, mul_x, mul_y, out_valid, out_prod, out_timeout, busy
  );

  modport slave (
    output in_valid, in_a, in_b, mul_prod, mul_ready, out_ready,
    input  in_ready, mul_reset, mul_x, mul_y, out_valid, out_prod, out_timeout, busy
  );
endinterface

// File: rtl/mult_operand_sequencer.sv
// Feeds operand pairs to a serial multiplier and pulses its load line.
// Zero operands skip the multiplier. Results are captured on ready or on timeout.
module mult_operand_sequencer #(
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  mult_operand_sequencer_if.master   bus
);

  // The counter spans GUARD and WAIT, so it must reach TIMEOUT without wrapping.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {IDLE, LOAD, GUARD, WAIT, OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [7:0]      x_q, x_d, y_q, y_d;
  logic [15:0]     prod_q, prod_d;
  logic            to_q, to_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      prod_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prod_q  <= prod_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    prod_d  = prod_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d = bus.in_a;
          y_d = bus.in_b;
          if (bus.in_a == 8'd0 || bus.in_b == 8'd0) begin
            state_d = OUT;
            prod_d  = '0;
            to_d    = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
      GUARD: begin
        // The multiplier is still settling after its load, so mul_ready is ignored here.
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(GUARD_CYCLES)) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (bus.mul_ready) begin
          prod_d  = bus.mul_prod;
          to_d    = 1'b0;
          state_d = OUT;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          prod_d  = bus.mul_prod;
          to_d    = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state_q == IDLE);
    bus.mul_reset   = (state_q == LOAD);
    bus.out_valid   = (state_q == OUT);
    bus.busy        = (state_q != IDLE);
    bus.mul_x       = x_q;
    bus.mul_y       = y_q;
    bus.out_prod    = prod_q;
    bus.out_timeout = to_q;
  end

endmodule

// File: doc/mult_operand_sequencer.md
MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

Interface
REQ-001 Parameter GUARD_CYCLES, default 2, cycles after the load pulse during which mul_ready SHALL be ignored.
REQ-002 Parameter TIMEOUT, default 12, maximum cycles after the load pulse to wait for mul_ready.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  sequencer can accept an operand pair.
REQ-007 in_a  input  8  first operand, unsigned.
REQ-008 in_b  input  8  second operand, unsigned.
REQ-009 mul_reset  output  1  active-high load/reset pulse to the downstream serial multiplier.
REQ-010 mul_x  output  8  first operand to the multiplier.
REQ-011 mul_y  output  8  second operand to the multiplier.
REQ-012 mul_prod  input  16  product from the multiplier.
REQ-013 mul_ready  input  1  multiplier result-ready flag.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_prod  output  16  captured product.
REQ-017 out_timeout  output  1  result was captured on timeout, not on mul_ready.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, LOAD, GUARD, WAIT and OUT; in_ready SHALL be 1 only in IDLE.
REQ-020 Accept SHALL occur on a cycle where in_valid=1 and in_ready=1; in_a/in_b SHALL be registered into mul_x/mul_y on that edge.
REQ-021 On accept with in_a!=0 and in_b!=0: IDLE->LOAD; mul_reset SHALL be 1 for exactly the one LOAD cycle.
REQ-022 On accept with in_a==0 or in_b==0 (zero bypass): IDLE->OUT directly; out_prod=0 and out_timeout=0; no mul_reset pulse.
REQ-023 LOAD->GUARD unconditionally; wait counter SHALL clear to 0 on entry to GUARD and increment by 1 each cycle in GUARD and WAIT.
REQ-024 GUARD->WAIT when counter reaches GUARD_CYCLES; mul_ready SHALL be ignored in LOAD and GUARD.
REQ-025 In WAIT, when mul_ready=1: capture mul_prod into out_prod, out_timeout=0, go to OUT.
REQ-026 In WAIT, when counter reaches TIMEOUT with mul_ready=0: capture mul_prod into out_prod, out_timeout=1, go to OUT.
REQ-027 If mul_ready=1 on the same cycle the counter reaches TIMEOUT, ready SHALL take priority (out_timeout=0).
REQ-028 In OUT: out_valid=1; out_prod and out_timeout SHALL hold stable until out_ready=1; OUT->IDLE on the edge where out_ready=1.
REQ-029 A new operand pair SHALL NOT be accepted on the cycle OUT completes; minimum accept-to-accept spacing is one IDLE cycle.
REQ-030 mul_x/mul_y SHALL hold the accepted operands from accept until the next accept.
REQ-031 mul_reset SHALL be 0 in every state other than LOAD.
REQ-032 The counter SHALL be at least 8 bits wide and SHALL NOT wrap within GUARD/WAIT for TIMEOUT<=255.

Reset
REQ-033 While reset=0, state SHALL be IDLE, and mul_reset, out_valid, out_timeout, busy, mul_x, mul_y, out_prod and the counter SHALL all be 0, asynchronously and without waiting for clk.
REQ-034 Reset asserted in any state SHALL abort the operation; the in-flight result SHALL be discarded and never presented.
REQ-035 After reset deassertion, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-036 Accept a=3, b=5; model asserts mul_ready with mul_prod=15 four cycles after LOAD -> exactly one mul_reset pulse with mul_x=3, mul_y=5; out_valid with out_prod=15, out_timeout=0.
REQ-037 Accept a=0, b=200 -> no mul_reset; out_valid on the cycle after accept with out_prod=0.
REQ-038 Hold mul_ready=1 throughout; accept a=7, b=9 -> mul_ready ignored for LOAD plus 2 GUARD cycles; capture occurs on the first WAIT cycle.
REQ-039 Hold mul_ready=0 with mul_prod=16'h1234 -> out_valid with out_prod=16'h1234 and out_timeout=1 after TIMEOUT counted cycles.
REQ-040 Result 255*255=65025 with out_ready=0 for 5 cycles -> out_prod stays 65025, in_ready=0, busy=1; then IDLE one cycle after out_ready=1.
REQ-041 Assert reset=0 mid-WAIT between edges -> all outputs are 0 immediately; after release, a=2, b=2 completes with out_prod=4.
